// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter_bank
//  Description : Ten performance counters for the memory-mapped perf I/O.
//                Eight event counters (branch / cache), optionally counted on
//                rising edges only, and two level-counted stall counters.
//                Each counter is cleared by its own strobe from the MMIO
//                decoder and either saturates or wraps at 2^WIDTH-1.
//  Ports       : clk, rst               clock, synchronous active-high reset
//                count_en               global enable (clears act regardless)
//                <name>_event           8 event inputs (branch, caches)
//                if_stall, mem_stall    level-counted stall inputs
//                <name>_count_reset     10 per-counter clear strobes
//                <name>_count           10 registered counter values
//  Revision    : 1.0  initial release
// ============================================================================
module perf_counter_bank #(
  parameter int WIDTH       = 16,
  parameter bit SATURATE    = 1'b1,
  parameter bit EDGE_EVENTS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             br_event,
  input  logic             br_mispredict_event,
  input  logic             icache_hit_event,
  input  logic             icache_miss_event,
  input  logic             dcache_hit_event,
  input  logic             dcache_miss_event,
  input  logic             l2_hit_event,
  input  logic             l2_miss_event,
  input  logic             if_stall,
  input  logic             mem_stall,
  input  logic             br_count_reset,
  input  logic             br_mispredict_count_reset,
  input  logic             icache_hit_count_reset,
  input  logic             icache_miss_count_reset,
  input  logic             dcache_hit_count_reset,
  input  logic             dcache_miss_count_reset,
  input  logic             l2_hit_count_reset,
  input  logic             l2_miss_count_reset,
  input  logic             if_stall_count_reset,
  input  logic             mem_stall_count_reset,
  output logic [WIDTH-1:0] br_count,
  output logic [WIDTH-1:0] br_mispredict_count,
  output logic [WIDTH-1:0] icache_hit_count,
  output logic [WIDTH-1:0] icache_miss_count,
  output logic [WIDTH-1:0] dcache_hit_count,
  output logic [WIDTH-1:0] dcache_miss_count,
  output logic [WIDTH-1:0] l2_hit_count,
  output logic [WIDTH-1:0] l2_miss_count,
  output logic [WIDTH-1:0] if_stall_count,
  output logic [WIDTH-1:0] mem_stall_count
);

  localparam int              c_NUM_CNT = 10;
  localparam int              c_NUM_EV  = 8;
  localparam logic [WIDTH-1:0] c_MAX    = '1;

  // Index order: the eight edge-capable events first, then the two stalls.
  logic [c_NUM_CNT-1:0] w_src;
  logic [c_NUM_CNT-1:0] w_clr;
  logic [c_NUM_CNT-1:0] w_inc;
  logic [WIDTH-1:0]     w_cnt [c_NUM_CNT];
  logic [c_NUM_EV-1:0]  r_ev_q;

  assign w_src = {mem_stall, if_stall,
                  l2_miss_event, l2_hit_event,
                  dcache_miss_event, dcache_hit_event,
                  icache_miss_event, icache_hit_event,
                  br_mispredict_event, br_event};

  assign w_clr = {mem_stall_count_reset, if_stall_count_reset,
                  l2_miss_count_reset, l2_hit_count_reset,
                  dcache_miss_count_reset, dcache_hit_count_reset,
                  icache_miss_count_reset, icache_hit_count_reset,
                  br_mispredict_count_reset, br_count_reset};

  // History tracks the raw inputs every cycle, independent of enable and
  // clears, so a strobe held across an enable toggle is not counted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_q <= '0;
    end else begin
      r_ev_q <= w_src[c_NUM_EV-1:0];
    end
  end

  generate
    for (genvar i = 0; i < c_NUM_CNT; i++) begin : g_inc
      if (i < c_NUM_EV && EDGE_EVENTS) begin : g_edge
        assign w_inc[i] = count_en & w_src[i] & ~r_ev_q[i];
      end else begin : g_level
        assign w_inc[i] = count_en & w_src[i];
      end
    end

    for (genvar i = 0; i < c_NUM_CNT; i++) begin : g_cnt
      logic [WIDTH-1:0] r_cnt;

      // Clear beats increment: a same-cycle event is deliberately dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_clr[i]) begin
          r_cnt <= '0;
        end else if (w_inc[i]) begin
          if (r_cnt == c_MAX) begin
            r_cnt <= SATURATE ? c_MAX : '0;
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
      end

      assign w_cnt[i] = r_cnt;
    end
  endgenerate

  assign br_count            = w_cnt[0];
  assign br_mispredict_count = w_cnt[1];
  assign icache_hit_count    = w_cnt[2];
  assign icache_miss_count   = w_cnt[3];
  assign dcache_hit_count    = w_cnt[4];
  assign dcache_miss_count   = w_cnt[5];
  assign l2_hit_count        = w_cnt[6];
  assign l2_miss_count       = w_cnt[7];
  assign if_stall_count      = w_cnt[8];
  assign mem_stall_count     = w_cnt[9];

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_counter_bank
//  Description : Directed self-checking bench for perf_counter_bank
//                (WIDTH=16, SATURATE=1, EDGE_EVENTS=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        count_en;
  logic [9:0]  ev;
  logic [9:0]  clr;
  logic [15:0] cnt [10];
  logic [15:0] c0, c1, c2, c3, c4, c5, c6, c7, c8, c9;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(
    .WIDTH(16), .SATURATE(1'b1), .EDGE_EVENTS(1'b1)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .count_en                  (count_en),
    .br_event                  (ev[0]),
    .br_mispredict_event       (ev[1]),
    .icache_hit_event          (ev[2]),
    .icache_miss_event         (ev[3]),
    .dcache_hit_event          (ev[4]),
    .dcache_miss_event         (ev[5]),
    .l2_hit_event              (ev[6]),
    .l2_miss_event             (ev[7]),
    .if_stall                  (ev[8]),
    .mem_stall                 (ev[9]),
    .br_count_reset            (clr[0]),
    .br_mispredict_count_reset (clr[1]),
    .icache_hit_count_reset    (clr[2]),
    .icache_miss_count_reset   (clr[3]),
    .dcache_hit_count_reset    (clr[4]),
    .dcache_miss_count_reset   (clr[5]),
    .l2_hit_count_reset        (clr[6]),
    .l2_miss_count_reset       (clr[7]),
    .if_stall_count_reset      (clr[8]),
    .mem_stall_count_reset     (clr[9]),
    .br_count                  (c0),
    .br_mispredict_count       (c1),
    .icache_hit_count          (c2),
    .icache_miss_count         (c3),
    .dcache_hit_count          (c4),
    .dcache_miss_count         (c5),
    .l2_hit_count              (c6),
    .l2_miss_count             (c7),
    .if_stall_count            (c8),
    .mem_stall_count           (c9)
  );

  always_comb begin
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3; cnt[4] = c4;
    cnt[5] = c5; cnt[6] = c6; cnt[7] = c7; cnt[8] = c8; cnt[9] = c9;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ev = '0; clr = '0; count_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; count_en = 1'b1; ev = '0; clr = '0;

    // Reset with every input high, then release with events still high.
    ev = '1;
    tick(); tick();
    for (int i = 0; i < 10; i++) check($sformatf("rst_zero[%0d]", i), cnt[i], 16'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) check($sformatf("post_rst[%0d]", i), cnt[i], 16'd1);

    // Edge detect: icache_hit high 5, low 1, high 3; if_stall high 7.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      ev[2] = (c != 5);
      ev[8] = (c < 7);
      tick();
    end
    ev = '0;
    tick();
    check("icache_hit_edges", cnt[2], 16'd2);
    check("if_stall_level", cnt[8], 16'd7);

    // Clear beats a simultaneous rising edge.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      ev[5] = 1'b1; tick();
      ev[5] = 1'b0; tick();
    end
    check("dmiss_five", cnt[5], 16'd5);
    ev[5] = 1'b1; clr[5] = 1'b1; tick();
    check("dmiss_clr_prio", cnt[5], 16'd0);
    ev[5] = 1'b0; clr[5] = 1'b0; tick();
    check("dmiss_hold0", cnt[5], 16'd0);
    ev[5] = 1'b1; tick();
    check("dmiss_after_clr", cnt[5], 16'd1);
    ev[5] = 1'b0;

    // count_en freeze, clear while frozen, strobe held across re-enable.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      ev[0] = 1'b1; tick();
      ev[0] = 1'b0; tick();
    end
    check("br_three", cnt[0], 16'd3);
    count_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ev[0] = ~ev[0];
      tick();
    end
    check("br_frozen", cnt[0], 16'd3);
    ev[0] = 1'b0; clr[0] = 1'b1; tick();
    check("br_clr_frozen", cnt[0], 16'd0);
    clr[0] = 1'b0; ev[0] = 1'b1; tick();
    count_en = 1'b1; tick();
    check("br_no_recount", cnt[0], 16'd0);
    ev[0] = 1'b0; tick();
    ev[0] = 1'b1; tick();
    check("br_new_edge", cnt[0], 16'd1);
    ev[0] = 1'b0;

    // All ten from 3, all increment with l2_miss cleared the same cycle.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      ev = '1; tick();
      ev = '0; tick();
    end
    for (int i = 0; i < 10; i++) check($sformatf("all_three[%0d]", i), cnt[i], 16'd3);
    ev = '1; clr[7] = 1'b1; tick();
    ev = '0; clr = '0;
    for (int i = 0; i < 10; i++)
      check($sformatf("simul[%0d]", i), cnt[i], (i == 7) ? 16'd0 : 16'd4);

    // Saturation of mem_stall.
    do_reset();
    ev[9] = 1'b1;
    for (int c = 0; c < 65535; c++) tick();
    check("mem_stall_max", cnt[9], 16'hFFFF);
    tick();
    check("mem_stall_sat", cnt[9], 16'hFFFF);
    ev[9] = 1'b0;
    check("other_idle", cnt[8], 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
